// File: rtl/fetch_pkg.sv
// Shared types and constants for the WISC instruction fetch stage.
package fetch_pkg;

   typedef enum logic [1:0] {
      REQ    = 2'd0,
      WAIT   = 2'd1,
      HALTED = 2'd2
   } fetch_state_t;

   localparam logic [15:0] NOP_INST         = 16'h0800;
   localparam logic [15:0] PC_STEP          = 16'd2;
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

   typedef struct packed {
      logic [15:0] inst;
      logic [15:0] pc_plus2;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Instruction memory read bus: fetch side is master, memory side is slave.
interface fetch_if;
   logic [15:0] imem_addr;
   logic        imem_rd;
   logic        imem_stall;
   logic        imem_done;
   logic [15:0] imem_data;

   modport master (output imem_addr, imem_rd, input imem_stall, imem_done, imem_data);
   modport slave  (input imem_addr, imem_rd, output imem_stall, imem_done, imem_data);
endinterface

// File: rtl/fetch_queue.sv
// In-order instruction queue: DEPTH entries of {inst, pc_plus2}, with flush.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  fetch_entry_t             push_entry,
   output fetch_entry_t             head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   fetch_entry_t   slots [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is deliberately not reset; the consumer masks the head while empty.
   always_ff @(posedge clk) begin
      if (push) slots[wr_ptr] <= push_entry;
   end

   assign head  = slots[rd_ptr];
   assign empty = (count == '0);

endmodule

// File: rtl/fetch_stage.sv
// WISC fetch stage: PC, request FSM, squash/err tracking and instruction queue.
// Optional FETCH_BYPASS_EN presents an unsquashed response combinationally when the queue is empty.
module fetch_stage
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic         clk,
   input  logic         rst,
   fetch_if.master      imem,
   output logic         if_valid,
   output logic [15:0]  if_inst,
   output logic [15:0]  if_pc_plus2,
   input  logic         id_ready,
   input  logic         redirect_valid,
   input  logic [15:0]  redirect_pc,
   input  logic         halt,
   output logic         err
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t  state, state_nxt;
   logic [15:0]   pc;
   logic          outstanding;
   logic          squash;

   logic [CW-1:0] q_count;
   logic          q_empty;
   fetch_entry_t  q_head;
   logic          q_push;
   logic          q_pop;

   logic          redirect_take;
   logic          accept_req;
   logic          resp_ok;
   logic          resp_keep;
   logic          bypass_eat;

   assign redirect_take = redirect_valid && (state != HALTED);
   assign accept_req    = imem.imem_rd && !imem.imem_stall;
   assign resp_ok       = imem.imem_done && outstanding;
   assign resp_keep     = resp_ok && !squash && !redirect_take;

`ifdef FETCH_BYPASS_EN
   assign bypass_eat = q_empty && resp_keep && id_ready;
`else
   assign bypass_eat = 1'b0;
`endif

   assign q_push = resp_keep && !bypass_eat;
   assign q_pop  = !q_empty && id_ready;

   always_ff @(posedge clk) begin
      if (rst) state <= REQ;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         REQ:     if (halt) state_nxt = HALTED;
                  else if (accept_req) state_nxt = WAIT;
         WAIT:    if (halt) state_nxt = HALTED;
                  else if (resp_ok) state_nxt = REQ;
         HALTED:  state_nxt = HALTED;
         default: state_nxt = REQ;
      endcase
   end

   // NOTE: every combinational output gets a default first, so no latch can be inferred.
   always_comb begin
      imem.imem_addr = pc;
      imem.imem_rd   = !rst && (state == REQ) && !halt && !redirect_take &&
                       ((32'(q_count) + 32'(outstanding)) < DEPTH);
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc          <= RESET_PC;
         outstanding <= 1'b0;
         squash      <= 1'b0;
         err         <= 1'b0;
      end else begin
         if (redirect_take)   pc <= redirect_pc;
         else if (accept_req) pc <= pc + PC_STEP;

         if (accept_req)   outstanding <= 1'b1;
         else if (resp_ok) outstanding <= 1'b0;

         if (resp_ok)                           squash <= 1'b0;
         else if (redirect_take && outstanding) squash <= 1'b1;

         if ((imem.imem_done && !outstanding) || (redirect_take && redirect_pc[0]))
            err <= 1'b1;
      end
   end

   // An unsquashed response implies pc has only advanced past its request, so pc is addr+2.
   fetch_queue #(.DEPTH(DEPTH)) u_queue (
      .clk        (clk),
      .rst        (rst),
      .push       (q_push),
      .pop        (q_pop),
      .flush      (redirect_take),
      .push_entry ('{inst: imem.imem_data, pc_plus2: pc}),
      .head       (q_head),
      .empty      (q_empty),
      .count      (q_count)
   );

   always_comb begin
      if_valid    = !q_empty;
      if_inst     = q_empty ? NOP_INST : q_head.inst;
      if_pc_plus2 = q_empty ? 16'h0000 : q_head.pc_plus2;
`ifdef FETCH_BYPASS_EN
      if (q_empty && resp_keep) begin
         if_valid    = 1'b1;
         if_inst     = imem.imem_data;
         if_pc_plus2 = pc;
      end
`endif
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized traffic vs. a program-order model.
module tb_fetch_stage;
   import fetch_pkg::*;

`ifdef FETCH_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        if_valid;
   logic [15:0] if_inst;
   logic [15:0] if_pc_plus2;
   logic        id_ready = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [15:0] redirect_pc = 16'h0000;
   logic        halt = 1'b0;
   logic        err;

   int n_checks = 0;
   int n_fail   = 0;

   fetch_if bus ();

   fetch_stage #(.DEPTH(2), .RESET_PC(16'h0000)) dut (
      .clk            (clk),
      .rst            (rst),
      .imem           (bus),
      .if_valid       (if_valid),
      .if_inst        (if_inst),
      .if_pc_plus2    (if_pc_plus2),
      .id_ready       (id_ready),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .halt           (halt),
      .err            (err)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   task automatic idle_inputs();
      bus.imem_stall = 1'b0;
      bus.imem_done  = 1'b0;
      bus.imem_data  = 16'h0000;
      redirect_valid = 1'b0;
      redirect_pc    = 16'h0000;
      halt           = 1'b0;
   endtask

   // Leaves the bench just after the edge that starts the first post-reset cycle.
   task automatic do_reset();
      rst = 1'b1;
      idle_inputs();
      next_cycle();
      settle();
      check("reset_rd_low", bus.imem_rd, 1'b0);
      next_cycle();
      rst = 1'b0;
   endtask

   // Memory contents seen by the random phase: any bijection of the address will do.
   function automatic logic [15:0] mem_word(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'hC3A5;
   endfunction

   logic [15:0] exp_fetch;
   logic [15:0] exp_pc;
   logic [15:0] resp_addr;
   bit          pend;
   int          cd;
   int          consumed;

   initial begin
      idle_inputs();

      // Zero-stall streaming, reset values and minimum latency
      do_reset();
      id_ready = 1'b1;
      settle();
      check("c0_rd", bus.imem_rd, 1'b1);
      check("c0_addr", bus.imem_addr, 16'h0000);
      check("c0_valid", if_valid, 1'b0);
      check("c0_inst_nop", if_inst, 16'h0800);
      check("c0_pcp2", if_pc_plus2, 16'h0000);
      check("c0_err", err, 1'b0);
      next_cycle();
      bus.imem_done = 1'b1; bus.imem_data = 16'h1111;
      settle();
      check("c1_rd", bus.imem_rd, 1'b0);
      check("c1_valid", if_valid, BYP);
      next_cycle();
      bus.imem_done = 1'b0;
      settle();
      check("c2_valid", if_valid, !BYP);
      check("c2_inst", if_inst, BYP ? 16'h0800 : 16'h1111);
      check("c2_pcp2", if_pc_plus2, BYP ? 16'h0000 : 16'h0002);
      check("c2_addr", bus.imem_addr, 16'h0002);
      check("c2_rd", bus.imem_rd, 1'b1);
      next_cycle();
      bus.imem_done = 1'b1; bus.imem_data = 16'h2222;
      next_cycle();
      bus.imem_done = 1'b0; bus.imem_stall = 1'b1;
      settle();
      check("c4_valid", if_valid, !BYP);
      check("c4_inst", if_inst, BYP ? 16'h0800 : 16'h2222);
      check("c4_pcp2", if_pc_plus2, BYP ? 16'h0000 : 16'h0004);
      check("stall_rd", bus.imem_rd, 1'b1);
      check("stall_addr", bus.imem_addr, 16'h0004);

      // Stalled request holds its address until accepted
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         settle();
         check("stall_rd", bus.imem_rd, 1'b1);
         check("stall_addr", bus.imem_addr, 16'h0004);
      end
      next_cycle();
      bus.imem_stall = 1'b0;
      settle();
      check("stall_acc_addr", bus.imem_addr, 16'h0004);
      next_cycle();
      bus.imem_done = 1'b1; bus.imem_data = 16'h3333;
      settle();
      check("stall_wait_rd", bus.imem_rd, 1'b0);
      next_cycle();
      bus.imem_done = 1'b0;
      settle();
      check("stall_inst", if_inst, BYP ? 16'h0800 : 16'h3333);
      check("stall_pcp2", if_pc_plus2, BYP ? 16'h0000 : 16'h0006);
      check("stall_next_addr", bus.imem_addr, 16'h0006);

      // Queue fills to DEPTH with decode blocked, then resumes after the first pop
      do_reset();
      id_ready = 1'b0;
      next_cycle();
      bus.imem_done = 1'b1; bus.imem_data = 16'hAAAA;
      next_cycle();
      bus.imem_done = 1'b0;
      settle();
      check("fill_addr1", bus.imem_addr, 16'h0002);
      next_cycle();
      bus.imem_done = 1'b1; bus.imem_data = 16'hBBBB;
      next_cycle();
      bus.imem_done = 1'b0;
      settle();
      check("fill_full_rd", bus.imem_rd, 1'b0);
      check("fill_head", if_inst, 16'hAAAA);
      check("fill_head_pc", if_pc_plus2, 16'h0002);
      next_cycle();
      id_ready = 1'b1;
      settle();
      check("fill_hold_rd", bus.imem_rd, 1'b0);
      check("fill_hold_inst", if_inst, 16'hAAAA);
      next_cycle();
      id_ready = 1'b0;
      settle();
      check("fill_resume_rd", bus.imem_rd, 1'b1);
      check("fill_resume_addr", bus.imem_addr, 16'h0004);
      check("fill_second", if_inst, 16'hBBBB);
      check("fill_second_pc", if_pc_plus2, 16'h0004);

      // Redirect while a request is outstanding squashes its response
      do_reset();
      id_ready = 1'b1;
      next_cycle();
      redirect_valid = 1'b1; redirect_pc = 16'h0040;
      next_cycle();
      redirect_valid = 1'b0;
      bus.imem_done = 1'b1; bus.imem_data = 16'hDEAD;
      settle();
      check("squash_no_bypass", if_valid, 1'b0);
      next_cycle();
      bus.imem_done = 1'b0;
      settle();
      check("squash_empty", if_valid, 1'b0);
      check("squash_rd", bus.imem_rd, 1'b1);
      check("squash_addr", bus.imem_addr, 16'h0040);
      check("squash_err", err, 1'b0);

      // Halt with one request outstanding
      do_reset();
      id_ready = 1'b0;
      next_cycle();
      halt = 1'b1;
      settle();
      check("halt_rd_c1", bus.imem_rd, 1'b0);
      next_cycle();
      halt = 1'b0;
      bus.imem_done = 1'b1; bus.imem_data = 16'h5555;
      settle();
      check("halt_rd_c2", bus.imem_rd, 1'b0);
      next_cycle();
      bus.imem_done = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 16'h0080;
      settle();
      check("halt_enq_valid", if_valid, 1'b1);
      check("halt_enq_inst", if_inst, 16'h5555);
      check("halt_enq_pc", if_pc_plus2, 16'h0002);
      next_cycle();
      redirect_valid = 1'b0;
      id_ready = 1'b1;
      settle();
      check("halt_redir_ignored", if_inst, 16'h5555);
      check("halt_rd_c4", bus.imem_rd, 1'b0);
      next_cycle();
      id_ready = 1'b0;
      settle();
      check("halt_drained", if_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         settle();
         check("halt_no_req", bus.imem_rd, 1'b0);
      end
      check("halt_err", err, 1'b0);

      // Done with nothing outstanding is a sticky error
      do_reset();
      bus.imem_stall = 1'b1;
      bus.imem_done = 1'b1; bus.imem_data = 16'h1234;
      next_cycle();
      bus.imem_done = 1'b0;
      settle();
      check("err_spurious", err, 1'b1);
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         settle();
         check("err_sticky", err, 1'b1);
      end

      // Odd redirect target raises err yet still loads pc
      do_reset();
      settle();
      check("err_cleared", err, 1'b0);
      bus.imem_stall = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 16'h0041;
      next_cycle();
      redirect_valid = 1'b0;
      bus.imem_stall = 1'b0;
      settle();
      check("err_odd", err, 1'b1);
      check("odd_addr", bus.imem_addr, 16'h0041);

      // Reset in WAIT: a late done right after reset is an error
      do_reset();
      next_cycle();
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      bus.imem_done = 1'b1; bus.imem_data = 16'h9999;
      settle();
      check("rstwait_addr", bus.imem_addr, 16'h0000);
      next_cycle();
      bus.imem_done = 1'b0;
      settle();
      check("rstwait_err", err, 1'b1);
      check("rstwait_valid", if_valid, 1'b0);

      // PC wraps from FFFE to 0000
      do_reset();
      id_ready = 1'b0;
      bus.imem_stall = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
      next_cycle();
      redirect_valid = 1'b0;
      bus.imem_stall = 1'b0;
      settle();
      check("wrap_addr", bus.imem_addr, 16'hFFFE);
      next_cycle();
      bus.imem_done = 1'b1; bus.imem_data = 16'h7777;
      next_cycle();
      bus.imem_done = 1'b0;
      settle();
      check("wrap_inst", if_inst, 16'h7777);
      check("wrap_pcp2", if_pc_plus2, 16'h0000);
      check("wrap_next_addr", bus.imem_addr, 16'h0000);

      // Random traffic against a program-order model
      do_reset();
      exp_fetch = 16'h0000;
      exp_pc    = 16'h0000;
      pend      = 1'b0;
      cd        = 0;
      resp_addr = 16'h0000;
      consumed  = 0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         bus.imem_done = 1'b0;
         bus.imem_data = 16'($urandom);
         if (pend) begin
            if (cd == 0) begin
               bus.imem_done = 1'b1;
               bus.imem_data = mem_word(resp_addr);
               pend = 1'b0;
            end else begin
               cd--;
            end
         end
         bus.imem_stall = ($urandom_range(3) == 0);
         id_ready       = ($urandom_range(2) != 0);
         redirect_valid = ($urandom_range(24) == 0);
         redirect_pc    = 16'($urandom) & 16'hFFFE;
         settle();
         if (bus.imem_rd && !bus.imem_stall) begin
            check("rnd_req_addr", bus.imem_addr, exp_fetch);
            check("rnd_single_outstanding", pend, 1'b0);
            pend      = 1'b1;
            cd        = $urandom_range(2);
            resp_addr = bus.imem_addr;
            exp_fetch = exp_fetch + 16'd2;
         end
         if (if_valid && id_ready) begin
            check("rnd_inst", if_inst, mem_word(exp_pc));
            check("rnd_pcp2", if_pc_plus2, exp_pc + 16'd2);
            exp_pc = exp_pc + 16'd2;
            consumed++;
         end
         if (redirect_valid) begin
            exp_fetch = redirect_pc;
            exp_pc    = redirect_pc;
         end
         next_cycle();
      end
      idle_inputs();
      settle();
      check("rnd_err", err, 1'b0);
      check("rnd_progress", consumed >= 200, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
